bambu_slave_port_master: RTL

BAMBU_SLAVE_PORT_MASTER -- requirements
Module: bambu_slave_port_master

---
 rtl/bambu_slave_port_master.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bambu_slave_port_master.sv
// Single-channel Bambu slave-port master: serialises byte accesses and kernel runs, one at a time.
// Access latency is at least 2 cycles from handshake to rsp_valid; cmd_ready is low outside IDLE.
module bambu_slave_port_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [6:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        run_req,
  output logic        run_busy,
  output logic        run_done,
  output logic [31:0] run_cycles,
  output logic        start_port,
  input  logic        done_port,
  output logic [1:0]  S_oe_ram,
  output logic [1:0]  S_we_ram,
  output logic [13:0] S_addr_ram,
  output logic [15:0] S_Wdata_ram,
  output logic [7:0]  S_data_ram_size,
  input  logic [15:0] Sout_Rdata_ram,
  input  logic [1:0]  Sout_DataRdy
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, MEM, RSP, RUN_START, RUN_WAIT, RUN_DONE
  } state_t;

  state_t        state_q;
  logic          we_q;
  logic [6:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic [31:0]   run_cnt_q;
  logic [31:0]   run_cnt_d;
  logic [31:0]   run_cycles_q;
  logic [7:0]    rsp_rdata_q;
  logic          rsp_err_q;
  logic          rsp_valid_q;
  logic          start_q;
  logic          busy_q;
  logic          run_done_q;
  logic          mem_act;

  assign tmo_d     = tmo_q + 1'b1;
  assign run_cnt_d = (&run_cnt_q) ? run_cnt_q : run_cnt_q + 32'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      tmo_q        <= '0;
      run_cnt_q    <= '0;
      run_cycles_q <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      start_q     <= 1'b0;
      run_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // A pending command always wins over a run request.
          if (cmd_valid) begin
            we_q    <= cmd_we;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            tmo_q   <= '0;
            state_q <= MEM;
          end else if (run_req) begin
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RUN_START;
          end
        end
        MEM: begin
          if (Sout_DataRdy[0]) begin
            rsp_rdata_q <= we_q ? 8'h00 : Sout_Rdata_ram[7:0];
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else if (tmo_q == TMO_LAST) begin
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        RSP: state_q <= IDLE;
        RUN_START: begin
          run_cnt_q <= '0;
          state_q   <= RUN_WAIT;
        end
        RUN_WAIT: begin
          // The cycle that samples done_port is counted too.
          run_cnt_q <= run_cnt_d;
          if (done_port) begin
            run_cycles_q <= run_cnt_d;
            run_done_q   <= 1'b1;
            state_q      <= RUN_DONE;
          end
        end
        RUN_DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_act = (state_q == MEM);

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign run_busy   = busy_q;
  assign run_done   = run_done_q;
  assign run_cycles = run_cycles_q;
  assign start_port = start_q;

  assign S_oe_ram        = {1'b0, mem_act & ~we_q};
  assign S_we_ram        = {1'b0, mem_act & we_q};
  assign S_addr_ram      = {7'd0, mem_act ? addr_q : 7'd0};
  assign S_Wdata_ram     = {8'd0, (mem_act & we_q) ? wdata_q : 8'd0};
  assign S_data_ram_size = {4'd0, mem_act ? 4'd8 : 4'd0};

  logic unused_ch1;
  assign unused_ch1 = ^{Sout_Rdata_ram[15:8], Sout_DataRdy[1]};

endmodule
